// File: rtl/flag_cond_unit.sv
// Architectural Z/N/C/V status register plus a condition-code evaluator.
// Requests and verdicts each use a valid/ready handshake; the verdict is registered.
module flag_cond_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       Z_in,
  input  logic       N_in,
  input  logic       C_in,
  input  logic       V_in,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_ready,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       cond_true,
  output logic       Z,
  output logic       N,
  output logic       C,
  output logic       V
);

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_LO = 4'd2,  CC_HS = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cc_e;

  logic r_z, r_n, r_c, r_v;
  logic r_result_valid;
  logic r_cond_true;

  logic w_accept;
  logic w_z, w_n, w_c, w_v;
  logic w_verdict;

  // The output register can take a new verdict whenever it is empty or being drained.
  assign cond_ready = !r_result_valid || result_ready;
  assign w_accept   = cond_valid && cond_ready;

  // A flag write in the accept cycle is visible to that request.
  always_comb begin
    w_z = r_z;
    w_n = r_n;
    w_c = r_c;
    w_v = r_v;
    if (flag_we) begin
      w_z = Z_in;
      w_n = N_in;
      w_c = C_in;
      w_v = V_in;
    end
  end

  always_comb begin
    w_verdict = 1'b0;
    case (cc_e'(cond))
      CC_EQ:   w_verdict = w_z;
      CC_NE:   w_verdict = !w_z;
      CC_LO:   w_verdict = w_c;
      CC_HS:   w_verdict = !w_c;
      CC_MI:   w_verdict = w_n;
      CC_PL:   w_verdict = !w_n;
      CC_VS:   w_verdict = w_v;
      CC_VC:   w_verdict = !w_v;
      CC_HI:   w_verdict = !w_c && !w_z;
      CC_LS:   w_verdict = w_c || w_z;
      CC_GE:   w_verdict = (w_n == w_v);
      CC_LT:   w_verdict = (w_n != w_v);
      CC_GT:   w_verdict = !w_z && (w_n == w_v);
      CC_LE:   w_verdict = w_z || (w_n != w_v);
      CC_AL:   w_verdict = 1'b1;
      CC_NV:   w_verdict = 1'b0;
      default: w_verdict = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (flag_we) begin
      r_z <= Z_in;
      r_n <= N_in;
      r_c <= C_in;
      r_v <= V_in;
    end
  end

  // Drain without accept keeps the last verdict on cond_true.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_valid <= 1'b0;
      r_cond_true    <= 1'b0;
    end else if (w_accept) begin
      r_result_valid <= 1'b1;
      r_cond_true    <= w_verdict;
    end else if (result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  assign result_valid = r_result_valid;
  assign cond_true    = r_cond_true;
  assign Z            = r_z;
  assign N            = r_n;
  assign C            = r_c;
  assign V            = r_v;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed vector table, hand-written handshake/reset
// sequences, and random traffic against an operand-level reference model.
module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we;
  logic       Z_in, N_in, C_in, V_in;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       result_valid;
  logic       result_ready;
  logic       cond_true;
  logic       Z, N, C, V;

  int n_cmp = 0;
  int n_err = 0;

  flag_cond_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag_we      (flag_we),
    .Z_in         (Z_in),
    .N_in         (N_in),
    .C_in         (C_in),
    .V_in         (V_in),
    .cond_valid   (cond_valid),
    .cond         (cond),
    .cond_ready   (cond_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .cond_true    (cond_true),
    .Z            (Z),
    .N            (N),
    .C            (C),
    .V            (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;  // {Z,N,C,V}
    logic [3:0] cc;
    logic       exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_we = 0; cond_valid = 0; cond = 0; result_ready = 1;
    {Z_in, N_in, C_in, V_in} = 4'b0000;
  endtask

  task automatic add(input logic [3:0] f, input logic [3:0] cc, input logic e);
    vec_t v;
    v.flags = f; v.cc = cc; v.exp = e;
    tbl.push_back(v);
  endtask

  // Flags of a-b as the subtractor would report them, from plain arithmetic.
  function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint      sd;
    logic        ovf;
    d   = a - b;
    sd  = longint'($signed(a)) - longint'($signed(b));
    ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {d == 32'd0, d[31], a < b, ovf};
  endfunction

  // Expected verdict expressed as the relation each code tests between a and b.
  function automatic logic rel_true(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cc);
    logic [3:0] f;
    f = flags_of(a, b);
    case (cc)
      4'd0:  return a == b;
      4'd1:  return a != b;
      4'd2:  return a < b;
      4'd3:  return a >= b;
      4'd4:  return f[2];
      4'd5:  return !f[2];
      4'd6:  return f[0];
      4'd7:  return !f[0];
      4'd8:  return a > b;
      4'd9:  return a <= b;
      4'd10: return $signed(a) >= $signed(b);
      4'd11: return $signed(a) < $signed(b);
      4'd12: return $signed(a) > $signed(b);
      4'd13: return $signed(a) <= $signed(b);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 0;
    #1;
    check("rst_valid", result_valid, 0);
    check("rst_true",  cond_true, 0);
    check("rst_ready", cond_ready, 1);
    check("rst_flags", {Z, N, C, V}, 4'b0000);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  logic [3:0] eq_exp  = 4'b0;
  logic [15:0] eq_seq = 16'b1001010101100110;  // cond 0..15, MSB first
  logic [15:0] z_seq  = 16'b0101010110101010;
  logic        held;

  // Random-phase model state
  logic [31:0] m_a, m_b, na, nb, fa, fb;
  logic        m_valid, m_true, acc;

  initial begin
    rst_n = 1;
    idle_inputs();
    #3;
    do_reset();

    // Vector table: flags per group, then back-to-back conditions.
    for (int i = 0; i < 16; i++) add(4'b1000, 4'(i), eq_seq[15-i]);
    add(4'b0010, 4'd2, 1); add(4'b0010, 4'd3, 0); add(4'b0010, 4'd8, 0); add(4'b0010, 4'd9, 1);
    add(4'b0001, 4'd10, 0); add(4'b0001, 4'd11, 1); add(4'b0001, 4'd6, 1);
    for (int i = 0; i < 16; i++) add(4'b0000, 4'(i), z_seq[15-i]);

    // Spot-check the operand-level flags against the table's flag patterns.
    check("ops_5m5",  flags_of(32'd5, 32'd5), 4'b1000);
    check("ops_1mff", flags_of(32'd1, 32'hFFFF_FFFF), 4'b0010);
    check("ops_ovf",  flags_of(32'h8000_0000, 32'd1), 4'b0001);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].flags != tbl[i-1].flags) begin
        idle_inputs();
        flag_we = 1;
        {Z_in, N_in, C_in, V_in} = tbl[i].flags;
        step();
        check($sformatf("tbl_flags%0d", i), {Z, N, C, V}, tbl[i].flags);
      end
      flag_we = 0; cond_valid = 1; cond = tbl[i].cc; result_ready = 1;
      step();
      check($sformatf("tbl_valid%0d", i), result_valid, 1);
      check($sformatf("tbl_cc%0d_v%0d", tbl[i].cc, i), cond_true, tbl[i].exp);
    end
    idle_inputs();
    step();
    check("drain_valid", result_valid, 0);

    // Reset mid-cycle with a pending verdict and flags=1111.
    flag_we = 1; {Z_in, N_in, C_in, V_in} = 4'b1111;
    cond_valid = 1; cond = 4'd0; result_ready = 0;
    step();
    check("pre_rst_valid", result_valid, 1);
    check("pre_rst_flags", {Z, N, C, V}, 4'b1111);
    do_reset();
    cond_valid = 1; cond = 4'd14; result_ready = 1;
    step();
    check("post_rst_al_valid", result_valid, 1);
    check("post_rst_al_true",  cond_true, 1);
    idle_inputs();
    step();

    // Forwarding: stored Z=0, write Z=1 in the accept cycle.
    check("fwd_stored_z", Z, 0);
    flag_we = 1; {Z_in, N_in, C_in, V_in} = 4'b1000;
    cond_valid = 1; cond = 4'd0; result_ready = 0;
    step();
    check("fwd_true",  cond_true, 1);
    check("fwd_valid", result_valid, 1);
    flag_we = 1; {Z_in, N_in, C_in, V_in} = 4'b0000; cond_valid = 0;
    step();
    check("fwd_frozen_z",    Z, 0);
    check("fwd_frozen_true", cond_true, 1);
    idle_inputs();
    step();

    // Back-pressure: hold a verdict for 3 cycles with a new request waiting.
    cond_valid = 1; cond = 4'd14; result_ready = 0;
    step();
    held = cond_true;
    check("bp_first", held, 1);
    cond = 4'd15;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_ready%0d", k), cond_ready, 0);
      step();
      check($sformatf("bp_valid%0d", k), result_valid, 1);
      check($sformatf("bp_true%0d", k),  cond_true, held);
    end
    result_ready = 1;
    #1;
    check("bp_ready_comb", cond_ready, 1);
    step();
    check("bp_swap_valid", result_valid, 1);
    check("bp_swap_true",  cond_true, 0);
    idle_inputs();
    step();

    // Random traffic against the operand-level model.
    do_reset();
    m_a = 32'd1; m_b = 32'd0; m_valid = 0; m_true = 0;
    for (int t = 0; t < 500; t++) begin
      na = $urandom;
      case ($urandom_range(0, 3))
        0: nb = na;
        1: nb = $urandom;
        2: nb = na + 32'd1;
        default: nb = 32'h8000_0000 ^ 32'($urandom_range(0, 1));
      endcase
      flag_we      = ($urandom_range(0, 2) == 0);
      {Z_in, N_in, C_in, V_in} = flags_of(na, nb);
      cond_valid   = ($urandom_range(0, 3) != 0);
      cond         = 4'($urandom_range(0, 15));
      result_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_ready", cond_ready, !m_valid || result_ready);
      acc = cond_valid && (!m_valid || result_ready);
      fa  = flag_we ? na : m_a;
      fb  = flag_we ? nb : m_b;
      if (acc) begin
        m_valid = 1;
        m_true  = rel_true(fa, fb, cond);
      end else if (result_ready) begin
        m_valid = 0;
      end
      if (flag_we) begin
        m_a = na; m_b = nb;
      end
      step();
      check("rnd_valid", result_valid, m_valid);
      check($sformatf("rnd_true_t%0d", t), cond_true, m_true);
      check("rnd_flags", {Z, N, C, V}, flags_of(m_a, m_b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
